// File: rtl/dbus_bridge.sv
// Data-memory bus bridge: turns the core's single-cycle SRAM-style access into a cyc/stb/ack bus
// transaction and stalls the pipeline until it completes. Optional bus timeout: DBUS_BRIDGE_TIMEOUT_EN.
module dbus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_hold_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        stall;
  logic        ack_hit;
  logic        timeout_hit;
  logic        req_we;
  logic [29:0] req_word;
  logic [3:0]  req_sel;
  logic [31:0] req_data;
  logic [31:0] rdata_q;
  logic        addr_lsb_unused;

  assign ack_hit         = (state == BUSY) && bus_ack_i;
  assign addr_lsb_unused = ^cpu_addr_i[1:0];

`ifdef DBUS_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        err_q;

  // Fires in the last allowed BUSY cycle; an ack in that same cycle takes priority.
  assign timeout_hit = (state == BUSY) && !bus_ack_i && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state != BUSY) begin
        wait_cnt <= '0;
      end else if (!bus_ack_i) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

  assign bus_err_o = err_q;
`else
  logic [15:0] timeout_cfg_unused;

  assign timeout_cfg_unused = 16'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
  assign bus_err_o          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        stall = cpu_ce_i;
        if (cpu_ce_i) state_next = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (ack_hit || timeout_hit) state_next = DONE;
      end
      DONE: begin
        if (!cpu_hold_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request is captured once on acceptance so later CPU input changes cannot leak onto the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_we   <= 1'b0;
      req_word <= '0;
      req_sel  <= '0;
      req_data <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && cpu_ce_i) begin
        req_we   <= cpu_we_i;
        req_word <= cpu_addr_i[31:2];
        req_sel  <= cpu_sel_i;
        req_data <= cpu_data_i;
      end
      if (!req_we) begin
        if (ack_hit) begin
          rdata_q <= bus_data_i;
        end else if (timeout_hit) begin
          rdata_q <= TIMEOUT_DATA;
        end
      end
    end
  end

  // Stall is gated by reset so the IDLE pass-through of cpu_ce_i stays quiet while held in reset.
  assign stallreq_o = stall & rst;
  assign cpu_data_o = rdata_q;
  assign bus_cyc_o  = (state == BUSY);
  assign bus_stb_o  = (state == BUSY);
  assign bus_we_o   = req_we;
  assign bus_addr_o = {req_word, 2'b00};
  assign bus_sel_o  = req_sel;
  assign bus_data_o = req_data;

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
Sits directly downstream of the CPU core's data-memory port (ram_ce/we/addr/sel/data) and converts its single-cycle SRAM-style request into a multi-cycle cyc/stb/ack bus transaction. Requests the pipeline stall through ctrl (stallreq_o) until the bus acknowledges. Returns read data to the mem stage and guarantees one bus transaction per CPU access, even while the pipeline is held by other stall sources.

Parameters:
TIMEOUT_CYCLES, 255, max cycles BUSY waits for bus_ack_i (used only with DBUS_BRIDGE_TIMEOUT_EN); range 1..65535
TIMEOUT_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
cpu_ce_i  in  1  CPU data access request (OR of core's ram_ce)
cpu_we_i  in  1  1 = write, 0 = read
cpu_addr_i  in  32  byte address
cpu_sel_i  in  4  byte enables
cpu_data_i  in  32  write data
cpu_hold_i  in  1  mem stage held by ctrl (stall[4]); keeps completed result presented
cpu_data_o  out  32  read data to mem stage
stallreq_o  out  1  stall request to ctrl
bus_cyc_o  out  1  bus cycle active
bus_stb_o  out  1  bus strobe
bus_we_o  out  1  bus write
bus_addr_o  out  32  bus address, word-aligned ([1:0] forced 0)
bus_sel_o  out  4  bus byte enables
bus_data_o  out  32  bus write data
bus_data_i  in  32  bus read data
bus_ack_i  in  1  bus acknowledge, single-cycle pulse
bus_err_o  out  1  timeout error pulse (tied 0 without macro)

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; latched request and read-data registers 0; timeout counter 0.
- States: IDLE, BUSY, DONE.
- IDLE: stallreq_o = cpu_ce_i (combinational, same cycle). If cpu_ce_i=1, latch we/addr/sel/data and go to BUSY next edge. Otherwise stay.
- BUSY: bus_cyc_o = bus_stb_o = 1. bus_we/addr/sel/data_o driven from latched registers, not from live CPU inputs. stallreq_o = 1. On bus_ack_i=1: latch bus_data_i if read (hold previous value on write), drop cyc/stb at next edge, go to DONE.
- DONE: stallreq_o = 0; cpu_data_o = latched read data. If cpu_hold_i=1, stay in DONE (no new transaction, even with cpu_ce_i=1). Else go to IDLE.
- cpu_data_o is registered and changes only on entry to DONE; it holds across IDLE.
- Latency: CPU request at cycle 0 with ack in the first BUSY cycle (cycle 1) gives stallreq low at cycle 2, which is the minimum 3-cycle access. Each extra bus wait cycle adds 1.
- Back-to-back: a new request is accepted in the IDLE cycle following DONE and stalls again from that cycle.
- bus_ack_i outside BUSY: ignored.
- cpu_ce_i dropping during BUSY: the transaction still completes (the bus cannot be aborted), then the FSM goes to DONE as normal.
- Reset mid-BUSY: cyc/stb drop immediately, with no completion.
- Live changes on cpu_* inputs during BUSY have no effect on bus outputs.

Optional Feature:
DBUS_BRIDGE_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop cyc/stb, pulse bus_err_o for 1 cycle, set cpu_data_o = TIMEOUT_DATA for reads (writes leave it unchanged), go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and there is no error.
- Undefined: no counter; BUSY waits indefinitely; bus_err_o constant 0.

Test Plan:
- Reset: rst=0 with random inputs -> all outputs 0, state IDLE. Release rst with cpu_ce_i=0 -> outputs remain 0.
- Read, zero-wait: cpu read addr 32'h0000_1006 at cycle 0, bus_data_i=32'h1234_5678 with ack at cycle 1 -> bus_addr_o=32'h0000_1004, stallreq 1 at cycles 0-1, cpu_data_o=32'h1234_5678 and stallreq 0 at cycle 2.
- Write, 3 wait states: we=1, sel=4'b0011, data 32'hA5A5_0F0F, ack at cycle 4 -> exactly one stb burst (cycles 1-4) with bus_we_o=1 and the latched data; stallreq drops at cycle 5.
- Hold: cpu_hold_i=1 for 4 cycles after DONE with cpu_ce_i still 1 -> no second bus_cyc_o, cpu_data_o stable. Releasing hold -> IDLE, then a new request is accepted.
- Input corruption: change cpu_addr_i/cpu_data_i every cycle during BUSY -> bus outputs keep the original latched values. Stray bus_ack_i during IDLE -> no state change.
- Timeout (macro defined, TIMEOUT_CYCLES=4, no ack) -> bus_err_o pulses once after 4 BUSY cycles, read returns 32'hDEADBEEF, stallreq drops the next cycle. Ack on the 4th cycle -> normal data, bus_err_o=0.
